ws2812b_serializer: RTL



---
 rtl/ws2812b_pkg.sv | 19 +
 rtl/ws2812b_bit_timer.sv | 38 +++
 rtl/ws2812b_serializer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ws2812b_pkg.sv
// Shared types and default 12 MHz timing for the WS2812B line driver.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  typedef logic [23:0] pixel_t;

  localparam int PIXEL_BITS       = 24;
  localparam int DEF_NUM_PIXELS   = 64;
  localparam int DEF_BIT_CYCLES   = 15;
  localparam int DEF_T0H_CYCLES   = 5;
  localparam int DEF_T1H_CYCLES   = 10;
  localparam int DEF_LATCH_CYCLES = 3600;

endpackage

// File: rtl/ws2812b_bit_timer.sv
// Bit-period timer: counts clk cycles inside one WS2812B bit, flags the last
// cycle of the period and decides the line level for the coming cycle.
module ws2812b_bit_timer
  import ws2812b_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int T0H_CYCLES = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES = DEF_T1H_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic next_bit,
  output logic wrap,
  output logic level_next
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T0H      = CNT_W'(T0H_CYCLES);
  localparam logic [CNT_W-1:0] T1H      = CNT_W'(T1H_CYCLES);

  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_next;

  assign wrap = (bit_cnt == CNT_LAST);

  // The counter sits at zero whenever the line is not sending, so a fresh
  // pixel always starts at the beginning of its first bit period.
  assign cnt_next   = (run && !wrap) ? bit_cnt + 1'b1 : '0;
  assign level_next = (cnt_next < (next_bit ? T1H : T0H));

  always_ff @(posedge clk) begin
    if (rst) bit_cnt <= '0;
    else     bit_cnt <= cnt_next;
  end

endmodule

// File: rtl/ws2812b_serializer.sv
// WS2812B line driver: takes GRB pixels over valid/ready, emits the NRZ
// waveform MSB first, then holds the line low for the latch period.
module ws2812b_serializer
  import ws2812b_pkg::*;
#(
  parameter int NUM_PIXELS   = DEF_NUM_PIXELS,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] i_pixel,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_data,
  output logic        o_busy,
  output logic        o_done
);

  localparam int PIX_W = $clog2(NUM_PIXELS + 1);
  localparam int LAT_W = $clog2(LATCH_CYCLES + 1);
  localparam logic [PIX_W-1:0] PIX_FULL  = PIX_W'(NUM_PIXELS);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [4:0]       IDX_FIRST = 5'(PIXEL_BITS - 1);

  state_t           state;
  pixel_t           shift;
  logic [4:0]       bit_idx;
  logic [PIX_W-1:0] pix_cnt;
  logic [LAT_W-1:0] latch_cnt;

  logic wrap;
  logic level_next;
  logic next_bit;
  logic pix_end;
  logic accept;

  assign pix_end = (state == SEND) && wrap && (bit_idx == '0);
  assign o_ready = !rst && ((state == IDLE) || (pix_end && (pix_cnt < PIX_FULL)));
  assign o_busy  = !rst && (state != IDLE);
  assign accept  = i_valid && o_ready;

  // Bit that will be on the line next cycle: a newly loaded pixel's MSB, the
  // following bit at a period boundary, or the current bit mid-period.
  always_comb begin
    next_bit = shift[23];
    if (accept)    next_bit = i_pixel[23];
    else if (wrap) next_bit = shift[22];
  end

  ws2812b_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES),
    .T0H_CYCLES(T0H_CYCLES),
    .T1H_CYCLES(T1H_CYCLES)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (state == SEND),
    .next_bit  (next_bit),
    .wrap      (wrap),
    .level_next(level_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      bit_idx   <= '0;
      pix_cnt   <= '0;
      latch_cnt <= '0;
      o_data    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          o_data <= 1'b0;
          if (accept) begin
            state   <= SEND;
            shift   <= i_pixel;
            bit_idx <= IDX_FIRST;
            pix_cnt <= pix_cnt + 1'b1;
            o_data  <= level_next;
          end
        end
        SEND: begin
          o_data <= level_next;
          if (wrap) begin
            if (bit_idx != '0) begin
              bit_idx <= bit_idx - 1'b1;
              shift   <= shift << 1;
            end else if (accept) begin
              shift   <= i_pixel;
              bit_idx <= IDX_FIRST;
              pix_cnt <= pix_cnt + 1'b1;
            end else if (pix_cnt == PIX_FULL) begin
              state     <= LATCH;
              latch_cnt <= '0;
              o_data    <= 1'b0;
            end else begin
              // Upstream starved us mid-frame; wait in IDLE for the next pixel.
              state  <= IDLE;
              o_data <= 1'b0;
            end
          end
        end
        LATCH: begin
          o_data <= 1'b0;
          if (latch_cnt == LAT_LAST) begin
            state     <= IDLE;
            latch_cnt <= '0;
            pix_cnt   <= '0;
            o_done    <= 1'b1;
          end else begin
            latch_cnt <= latch_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          o_data <= 1'b0;
        end
      endcase
    end
  end

endmodule
